// File: rtl/snn_pkg.sv
// Shared definitions for the spiking layer engine: FSM encoding and default widths.
package snn_pkg;

  localparam int DEF_W_W = 8;
  localparam int DEF_V_W = 12;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_UPD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/lif_layer_eng_if.sv
// Sequencer and weight-memory signals of the LIF layer engine.
interface lif_layer_eng_if #(
  parameter int N_IN  = 16,
  parameter int N_OUT = 8,
  parameter int W_W   = 8
);
  localparam int AW = $clog2(N_IN * N_OUT);

  logic                  st;
  logic [N_IN-1:0]       in_spk;
  logic                  v_clr;
  logic                  w_rd;
  logic [AW-1:0]         w_addr;
  logic signed [W_W-1:0] w_data;
  logic [N_OUT-1:0]      out_spk;
  logic                  busy;
  logic                  d;

  modport master (
    output st, in_spk, v_clr, w_data,
    input  w_rd, w_addr, out_spk, busy, d
  );

  modport slave (
    input  st, in_spk, v_clr, w_data,
    output w_rd, w_addr, out_spk, busy, d
  );

endinterface

// File: rtl/lif_upd.sv
// Combinational leaky integrate-and-fire step: leak, integrate, saturate, fire.
module lif_upd #(
  parameter int V_W     = 12,
  parameter int A_W     = 13,
  parameter int THRESH  = 256,
  parameter int LEAK_SH = 3
) (
  input  logic signed [V_W-1:0] v,
  input  logic signed [A_W-1:0] acc,
  output logic signed [V_W-1:0] v_next,
  output logic                  fire
);
  // Two guard bits over the wider operand keep v - leak + acc exact before clamping.
  localparam int EW    = ((V_W > A_W) ? V_W : A_W) + 2;
  localparam int V_MAX = (2 ** (V_W - 1)) - 1;
  localparam int V_MIN = -(2 ** (V_W - 1));

  logic signed [EW-1:0]  v_ext_s;
  logic signed [EW-1:0]  leak_s;
  logic signed [EW-1:0]  sum_s;
  logic signed [V_W-1:0] v_sat_s;

  // Leak, integrate and clamp; a firing neuron restarts from zero.
  always_comb begin
    v_ext_s = EW'(v);
    leak_s  = v_ext_s >>> LEAK_SH;
    sum_s   = v_ext_s - leak_s + EW'(acc);
    if (sum_s > EW'(V_MAX)) begin
      v_sat_s = V_W'(V_MAX);
    end else if (sum_s < EW'(V_MIN)) begin
      v_sat_s = V_W'(V_MIN);
    end else begin
      v_sat_s = sum_s[V_W-1:0];
    end
    fire = (v_sat_s >= V_W'(THRESH));
    if (fire) begin
      v_next = '0;
    end else begin
      v_next = v_sat_s;
    end
  end

endmodule

// File: rtl/lif_layer_eng.sv
// LIF layer engine: reads one weight per (neuron, input) pair, accumulates the
// spike-gated weights per neuron and applies a leaky integrate-and-fire update.
module lif_layer_eng
  import snn_pkg::*;
#(
  parameter int N_IN    = 16,
  parameter int N_OUT   = 8,
  parameter int W_W     = DEF_W_W,
  parameter int V_W     = DEF_V_W,
  parameter int THRESH  = 256,
  parameter int LEAK_SH = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  lif_layer_eng_if.slave bus
);
  localparam int AW  = $clog2(N_IN * N_OUT);
  localparam int IW  = $clog2(N_IN);
  localparam int JW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int A_W = W_W + $clog2(N_IN) + 1;

  state_t                state_r, state_nxt_s;
  logic [IW-1:0]         i_r, i_nxt_s, i_d_r;
  logic [JW-1:0]         j_r, j_nxt_s;
  logic signed [A_W-1:0] acc_r, acc_nxt_s, acc_add_s;
  logic [N_IN-1:0]       spk_in_r, spk_in_nxt_s;
  logic [N_OUT-1:0]      stage_r, stage_nxt_s;
  logic signed [V_W-1:0] v_r [N_OUT];
  logic signed [V_W-1:0] v_next_s;
  logic                  fire_s, v_upd_s, v_clr_s;
  logic                  rd_d_r;
  logic                  w_rd_r;
  logic [AW-1:0]         w_addr_r, addr_nxt_s;
  logic [N_OUT-1:0]      out_spk_r;
  logic                  busy_r, d_r;

  lif_upd #(
    .V_W     (V_W),
    .A_W     (A_W),
    .THRESH  (THRESH),
    .LEAK_SH (LEAK_SH)
  ) u_upd (
    .v      (v_r[j_r]),
    .acc    (acc_r),
    .v_next (v_next_s),
    .fire   (fire_s)
  );

  // Weight data arrives one cycle after its read, so gate with the delayed read/index.
  always_comb begin
    acc_add_s = acc_r;
    if (rd_d_r && spk_in_r[i_d_r]) begin
      acc_add_s = acc_r + {{(A_W - W_W){bus.w_data[W_W-1]}}, bus.w_data};
    end else begin
      acc_add_s = acc_r;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_nxt_s  = state_r;
    i_nxt_s      = i_r;
    j_nxt_s      = j_r;
    acc_nxt_s    = acc_r;
    spk_in_nxt_s = spk_in_r;
    stage_nxt_s  = stage_r;
    v_upd_s      = 1'b0;
    v_clr_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.st) begin
          state_nxt_s  = S_RD;
          i_nxt_s      = '0;
          j_nxt_s      = '0;
          acc_nxt_s    = '0;
          spk_in_nxt_s = bus.in_spk;
          stage_nxt_s  = '0;
        end else if (bus.v_clr) begin
          v_clr_s = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_RD: begin
        acc_nxt_s = acc_add_s;
        if (i_r == IW'(N_IN - 1)) begin
          state_nxt_s = S_WAIT;
        end else begin
          i_nxt_s = i_r + IW'(1);
        end
      end
      S_WAIT: begin
        acc_nxt_s   = acc_add_s;
        state_nxt_s = S_UPD;
      end
      S_UPD: begin
        v_upd_s          = 1'b1;
        stage_nxt_s[j_r] = fire_s;
        if (j_r == JW'(N_OUT - 1)) begin
          state_nxt_s = S_DONE;
        end else begin
          j_nxt_s     = j_r + JW'(1);
          i_nxt_s     = '0;
          acc_nxt_s   = '0;
          state_nxt_s = S_RD;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // Address for the read issued in the upcoming cycle.
  always_comb begin
    if (state_nxt_s == S_RD) begin
      addr_nxt_s = AW'(j_nxt_s) * AW'(N_IN) + AW'(i_nxt_s);
    end else begin
      addr_nxt_s = '0;
    end
  end

  // FSM state, counters, accumulator and latched spikes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      i_r      <= '0;
      j_r      <= '0;
      acc_r    <= '0;
      spk_in_r <= '0;
      stage_r  <= '0;
      i_d_r    <= '0;
      rd_d_r   <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      i_r      <= i_nxt_s;
      j_r      <= j_nxt_s;
      acc_r    <= acc_nxt_s;
      spk_in_r <= spk_in_nxt_s;
      stage_r  <= stage_nxt_s;
      i_d_r    <= i_r;
      rd_d_r   <= w_rd_r;
    end
  end

  // Membrane potentials persist across runs; cleared only by reset or v_clr in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) v_r[k] <= '0;
    end else if (v_clr_s) begin
      for (int k = 0; k < N_OUT; k++) v_r[k] <= '0;
    end else if (v_upd_s) begin
      v_r[j_r] <= v_next_s;
    end else begin
      v_r <= v_r;
    end
  end

  // Registered outputs; d and out_spk follow the DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_rd_r    <= 1'b0;
      w_addr_r  <= '0;
      busy_r    <= 1'b0;
      d_r       <= 1'b0;
      out_spk_r <= '0;
    end else begin
      w_rd_r   <= (state_nxt_s == S_RD);
      w_addr_r <= addr_nxt_s;
      busy_r   <= (state_nxt_s != S_IDLE);
      d_r      <= (state_r == S_DONE);
      if (state_r == S_DONE) begin
        out_spk_r <= stage_r;
      end else begin
        out_spk_r <= out_spk_r;
      end
    end
  end

  assign bus.w_rd    = w_rd_r;
  assign bus.w_addr  = w_addr_r;
  assign bus.busy    = busy_r;
  assign bus.d       = d_r;
  assign bus.out_spk = out_spk_r;

endmodule

// File: doc/lif_layer_eng.md
LIF_LAYER_ENG -- requirements
Module: lif_layer_eng

Interface
REQ-001 Parameter N_IN, 16: number of input spike lines (>=2).
REQ-002 Parameter N_OUT, 8: number of neurons in the layer (>=1).
REQ-003 Parameter W_W, 8: signed weight width.
REQ-004 Parameter V_W, 12: signed membrane potential width.
REQ-005 Parameter THRESH, 256: firing threshold, signed V_W.
REQ-006 Parameter LEAK_SH, 3: leak shift amount; leak = v >>> LEAK_SH.
REQ-007 Port clk  input  1  single clock, rising edge.
REQ-008 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-009 Port st  input  1  start pulse from the network sequencer.
REQ-010 Port in_spk  input  N_IN  input spike vector, sampled with st.
REQ-011 Port v_clr  input  1  clear all membrane potentials; honoured only in IDLE.
REQ-012 Port w_rd  output  1  weight memory read strobe.
REQ-013 Port w_addr  output  clog2(N_IN*N_OUT)  weight address = j*N_IN + i.
REQ-014 Port w_data  input  W_W  signed weight, valid exactly one cycle after its w_rd.
REQ-015 Port out_spk  output  N_OUT  registered output spikes of the last completed run.
REQ-016 Port busy  output  1  high in every state except IDLE.
REQ-017 Port d  output  1  done pulse, exactly one cycle per accepted st.

Function
REQ-018 FSM states SHALL be IDLE, RD, WAIT, UPD, DONE.
REQ-019 In IDLE, st=1 SHALL latch in_spk, set j=0, i=0 and acc=0, and move to RD.
REQ-020 In IDLE with st=0 and v_clr=1, all membranes SHALL be zeroed at the next edge; if st and v_clr are both high, st wins and v_clr is ignored.
REQ-021 st SHALL be ignored while busy=1; no queuing.
REQ-022 In RD, w_rd=1 and w_addr=j*N_IN+i; i SHALL increment; at i=N_IN-1 the next state SHALL be WAIT.
REQ-023 w_rd and w_addr SHALL be 0 outside RD.
REQ-024 A one-cycle delayed copy of i and w_rd SHALL gate accumulation: acc += w_data only if delayed w_rd=1 and latched spike bit[i_d]=1; this happens in RD and WAIT.
REQ-025 acc SHALL be W_W+clog2(N_IN)+1 bits signed and SHALL never overflow.
REQ-026 WAIT SHALL last one cycle, then go to UPD.
REQ-027 In UPD, v_new = sat_V_W(v[j] - (v[j] >>> LEAK_SH) + acc).
REQ-028 If v_new >= THRESH, spike bit j SHALL be set and v[j] SHALL be set to 0; otherwise v[j] SHALL be set to v_new.
REQ-029 After UPD, if j=N_OUT-1 the next state SHALL be DONE; otherwise j SHALL increment, i and acc SHALL clear, and the next state SHALL be RD.
REQ-030 Saturation SHALL clamp to [-2^(V_W-1), 2^(V_W-1)-1].
REQ-031 In DONE, d=1 and out_spk SHALL load the staged spike vector; the next state SHALL be IDLE.
REQ-032 Latency: d SHALL be high exactly N_OUT*(N_IN+2)+1 cycles after the edge that samples st.
REQ-033 out_spk SHALL hold its value between runs; membranes SHALL persist across runs.

Reset
REQ-034 rst_n low SHALL force, asynchronously: state IDLE; i, j, acc and staged spikes 0; all membranes 0; out_spk, busy, d, w_rd and w_addr 0.
REQ-035 Reset mid-run SHALL abort the run with no d pulse; the first st after release SHALL start a clean run.

Structure
REQ-036 Package snn_pkg SHALL hold the FSM state encoding and the default widths W_W and V_W.
REQ-037 The saturating leak/threshold update SHALL be a combinational sub-module lif_upd (inputs v, acc; outputs v_next, fire).
REQ-038 Membranes SHALL be an N_OUT x V_W register array local to lif_layer_eng.

Verification (N_IN=4, N_OUT=2, THRESH=256, LEAK_SH=3)
REQ-039 Scenario 1: st with in_spk=4'b1111, all weights 100 -> w_addr sequence 0..7, d at cycle 13, out_spk=2'b11, v=0.
REQ-040 Scenario 2: in_spk=4'b0101, weights 50 -> acc=100, no spike; second identical run gives v=100-12+100=188, out_spk=00.
REQ-041 Scenario 3: weights -127, all spikes, repeated runs -> v saturates at -2048 and never wraps.
REQ-042 Scenario 4: st pulses during busy -> exactly one d per accepted st; w_addr stream undisturbed.
REQ-043 Scenario 5: rst_n low at cycle 6 of a run -> no d, all outputs 0; the next run matches Scenario 1.
REQ-044 Scenario 6: st and v_clr high together in IDLE -> run starts and membranes are not cleared; v_clr alone -> v=0.
